// File: rtl/alu8_pkg.sv
// Shared types and helpers for the 8-bit "ALU A,n" execution block.
// Holds the op and FSM encodings, the F-register bit positions and the parity/decode helpers.
package alu8_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPND = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_X  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  // 1 when the byte holds an even number of set bits.
  function automatic logic parity_even(input logic [7:0] v);
    return ~(^v);
  endfunction

  // Strobe order is {ADD, ADC, SUB, SBC, AND, OR, XOR}; SUB without write-A is a compare.
  function automatic op_e decode_op(input logic [6:0] strobes, input logic write_a);
    op_e op;
    if (strobes[6]) begin
      op = OP_ADD;
    end else if (strobes[5]) begin
      op = OP_ADC;
    end else if (strobes[4]) begin
      if (write_a) begin
        op = OP_SUB;
      end else begin
        op = OP_CP;
      end
    end else if (strobes[3]) begin
      op = OP_SBC;
    end else if (strobes[2]) begin
      op = OP_AND;
    end else if (strobes[1]) begin
      op = OP_OR;
    end else begin
      op = OP_XOR;
    end
    return op;
  endfunction

endpackage

// File: rtl/alu8_flag_calc.sv
// Combinational result and Z80 flag generation for one ALU A,n operation.
import alu8_pkg::*;

module alu8_flag_calc #(
  parameter bit CP_XY_FROM_N = 1'b1
) (
  input  op_e        op,
  input  logic [7:0] a,
  input  logic [7:0] n,
  input  logic       cin,
  output logic [7:0] r,
  output logic [7:0] f
);

  logic       c_s;
  logic [8:0] wide_s;
  logic [4:0] nib_s;
  logic       h_s;
  logic       cy_s;
  logic       pv_s;
  logic       sub_s;
  logic [7:0] xy_s;

  // Arithmetic/logic core: bit 8 of wide_s and bit 4 of nib_s carry the carry/borrow outs.
  always_comb begin
    c_s    = 1'b0;
    wide_s = 9'd0;
    nib_s  = 5'd0;
    h_s    = 1'b0;
    cy_s   = 1'b0;
    pv_s   = 1'b0;
    sub_s  = 1'b0;
    if (op == OP_ADC || op == OP_SBC) begin
      c_s = cin;
    end else begin
      c_s = 1'b0;
    end
    case (op)
      OP_ADD, OP_ADC: begin
        wide_s = {1'b0, a} + {1'b0, n} + {8'd0, c_s};
        nib_s  = {1'b0, a[3:0]} + {1'b0, n[3:0]} + {4'd0, c_s};
        h_s    = nib_s[4];
        cy_s   = wide_s[8];
        pv_s   = (a[7] == n[7]) && (wide_s[7] != a[7]);
      end
      OP_SUB, OP_SBC, OP_CP: begin
        wide_s = {1'b0, a} - {1'b0, n} - {8'd0, c_s};
        nib_s  = {1'b0, a[3:0]} - {1'b0, n[3:0]} - {4'd0, c_s};
        h_s    = nib_s[4];
        cy_s   = wide_s[8];
        pv_s   = (a[7] != n[7]) && (wide_s[7] != a[7]);
        sub_s  = 1'b1;
      end
      OP_AND: begin
        wide_s = {1'b0, a & n};
        h_s    = 1'b1;
        pv_s   = parity_even(a & n);
      end
      OP_OR: begin
        wide_s = {1'b0, a | n};
        pv_s   = parity_even(a | n);
      end
      OP_XOR: begin
        wide_s = {1'b0, a ^ n};
        pv_s   = parity_even(a ^ n);
      end
      default: begin
        wide_s = 9'd0;
      end
    endcase
  end

  // Flag assembly; a compare may take the undocumented X/Y bits from the operand.
  always_comb begin
    f = 8'd0;
    r = wide_s[7:0];
    if (op == OP_CP && CP_XY_FROM_N) begin
      xy_s = n;
    end else begin
      xy_s = wide_s[7:0];
    end
    f[FLAG_S]  = wide_s[7];
    f[FLAG_Z]  = (wide_s[7:0] == 8'd0);
    f[FLAG_Y]  = xy_s[5];
    f[FLAG_H]  = h_s;
    f[FLAG_X]  = xy_s[3];
    f[FLAG_PV] = pv_s;
    f[FLAG_N]  = sub_s;
    f[FLAG_C]  = cy_s;
  end

endmodule

// File: rtl/alu8_imm_exec.sv
// Executes a decoded "ALU A,n": fetches the immediate over req/valid, computes, writes back A/F.
import alu8_pkg::*;

module alu8_imm_exec #(
  parameter int TIMEOUT      = 16,
  parameter bit CP_XY_FROM_N = 1'b1
) (
  input  logic       CLK,
  input  logic       notRESET,
  input  logic       start,
  input  logic       PA_ADD,
  input  logic       PA_ADC,
  input  logic       PA_SUB,
  input  logic       PA_SBC,
  input  logic       PA_AND,
  input  logic       PA_OR,
  input  logic       PA_XOR,
  input  logic       PR_Write_A,
  input  logic [7:0] A_in,
  input  logic [7:0] F_in,
  output logic       n_req,
  input  logic       n_valid,
  input  logic [7:0] n_data,
  output logic [7:0] A_out,
  output logic       A_we,
  output logic [7:0] F_out,
  output logic       F_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int          CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT);

  state_e         state_r, state_s;
  op_e            op_r, op_s;
  logic [7:0]     a_r, a_s, n_r, n_s;
  logic           cin_r, cin_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [7:0]     a_out_r, a_out_s, f_out_r, f_out_s;
  logic           n_req_r, n_req_s, a_we_r, a_we_s, f_we_r, f_we_s;
  logic           busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [6:0]     strobes_s;
  logic           legal_s;
  logic           timeout_hit_s;
  logic [7:0]     res_s, flags_s;
  logic           unused_s;

  // Only the carry bit of the incoming flags matters here.
  assign unused_s      = ^F_in[7:1];
  assign strobes_s     = {PA_ADD, PA_ADC, PA_SUB, PA_SBC, PA_AND, PA_OR, PA_XOR};
  assign legal_s       = ($countones(strobes_s) == 1);
  assign timeout_hit_s = (TIMEOUT_U != 32'd0) && ((32'(cnt_r) + 32'd1) == TIMEOUT_U);

  alu8_flag_calc #(
    .CP_XY_FROM_N(CP_XY_FROM_N)
  ) u_flag_calc (
    .op  (op_r),
    .a   (a_r),
    .n   (n_r),
    .cin (cin_r),
    .r   (res_s),
    .f   (flags_s)
  );

  // Next-state and next-output logic; strobes default low so they pulse for one cycle.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    a_s     = a_r;
    n_s     = n_r;
    cin_s   = cin_r;
    cnt_s   = cnt_r;
    a_out_s = a_out_r;
    f_out_s = f_out_r;
    n_req_s = 1'b0;
    a_we_s  = 1'b0;
    f_we_s  = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (legal_s) begin
            op_s    = decode_op(strobes_s, PR_Write_A);
            a_s     = A_in;
            cin_s   = F_in[0];
            cnt_s   = {CW{1'b0}};
            n_req_s = 1'b1;
            state_s = ST_OPND;
          end else begin
            err_s  = 1'b1;
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OPND: begin
        if (n_valid) begin
          n_s     = n_data;
          state_s = ST_EXEC;
        end else if (timeout_hit_s) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          n_req_s = 1'b1;
          cnt_s   = cnt_r + CW'(1);
        end
      end
      ST_EXEC: begin
        a_out_s = res_s;
        f_out_s = flags_s;
        f_we_s  = 1'b1;
        done_s  = 1'b1;
        a_we_s  = (op_r != OP_CP);
        state_s = ST_WB;
      end
      ST_WB: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, latched operands and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge notRESET) begin
    if (!notRESET) begin
      state_r <= ST_IDLE;
      op_r    <= OP_ADD;
      a_r     <= 8'd0;
      n_r     <= 8'd0;
      cin_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      a_out_r <= 8'd0;
      f_out_r <= 8'd0;
      n_req_r <= 1'b0;
      a_we_r  <= 1'b0;
      f_we_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      a_r     <= a_s;
      n_r     <= n_s;
      cin_r   <= cin_s;
      cnt_r   <= cnt_s;
      a_out_r <= a_out_s;
      f_out_r <= f_out_s;
      n_req_r <= n_req_s;
      a_we_r  <= a_we_s;
      f_we_r  <= f_we_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign n_req = n_req_r;
  assign A_out = a_out_r;
  assign A_we  = a_we_r;
  assign F_out = f_out_r;
  assign F_we  = f_we_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;

endmodule

// File: tb/tb_alu8_imm_exec.sv
// Randomized self-checking bench for alu8_imm_exec against an arithmetic reference model.
module tb_alu8_imm_exec;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       notRESET = 1'b0;
  logic       start = 1'b0;
  logic       PA_ADD = 1'b0, PA_ADC = 1'b0, PA_SUB = 1'b0, PA_SBC = 1'b0;
  logic       PA_AND = 1'b0, PA_OR = 1'b0, PA_XOR = 1'b0;
  logic       PR_Write_A = 1'b1;
  logic [7:0] A_in = 8'd0, F_in = 8'd0, n_data = 8'd0;
  logic       n_valid = 1'b0;
  logic       n_req, A_we, F_we, busy, done, err;
  logic [7:0] A_out, F_out;

  int total = 0;
  int bad = 0;
  int exp_a = 0;
  int exp_f = 0;

  always #5 CLK = ~CLK;

  alu8_imm_exec #(.TIMEOUT(TO), .CP_XY_FROM_N(1'b1)) dut (
    .CLK(CLK), .notRESET(notRESET), .start(start),
    .PA_ADD(PA_ADD), .PA_ADC(PA_ADC), .PA_SUB(PA_SUB), .PA_SBC(PA_SBC),
    .PA_AND(PA_AND), .PA_OR(PA_OR), .PA_XOR(PA_XOR), .PR_Write_A(PR_Write_A),
    .A_in(A_in), .F_in(F_in), .n_req(n_req), .n_valid(n_valid), .n_data(n_data),
    .A_out(A_out), .A_we(A_we), .F_out(F_out), .F_we(F_we),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Ops are numbered ADD=0 ADC=1 SUB=2 SBC=3 AND=4 OR=5 XOR=6 CP=7.
  function automatic void model(input int op, input int a, input int n, input int cin,
                                output int r, output int f);
    int c, full, nib, sa, sn, sr, h, cy, pv, nf, ones, y, x;
    c = (op == 1 || op == 3) ? cin : 0;
    sa = (a > 127) ? a - 256 : a;
    sn = (n > 127) ? n - 256 : n;
    h = 0; cy = 0; pv = 0; nf = 0; full = 0;
    if (op <= 1) begin
      full = a + n + c;
      nib  = (a % 16) + (n % 16) + c;
      h    = (nib > 15);
      cy   = (full > 255);
      sr   = sa + sn + c;
      pv   = (sr > 127 || sr < -128);
    end else if (op == 2 || op == 3 || op == 7) begin
      full = a - n - c;
      nib  = (a % 16) - (n % 16) - c;
      h    = (nib < 0);
      cy   = (full < 0);
      sr   = sa - sn - c;
      pv   = (sr > 127 || sr < -128);
      nf   = 1;
    end else begin
      if (op == 4) begin
        full = a & n;
        h = 1;
      end else if (op == 5) begin
        full = a | n;
      end else begin
        full = a ^ n;
      end
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (full >> i) & 1;
      pv = (ones % 2 == 0);
    end
    r = full & 255;
    y = (op == 7) ? (n >> 5) & 1 : (r >> 5) & 1;
    x = (op == 7) ? (n >> 3) & 1 : (r >> 3) & 1;
    f = ((r >> 7) << 7) | ((r == 0) << 6) | (y << 5) | (h << 4) | (x << 3) |
        (pv << 2) | (nf << 1) | cy;
  endfunction

  task automatic set_strobes(input logic [6:0] s, input logic wa);
    {PA_ADD, PA_ADC, PA_SUB, PA_SBC, PA_AND, PA_OR, PA_XOR} = s;
    PR_Write_A = wa;
  endtask

  task automatic drive_op_strobes(input int op);
    logic [6:0] one;
    one = 7'b1000000;
    if (op == 7) set_strobes(7'b0010000, 1'b0);
    else         set_strobes(one >> op, 1'b1);
  endtask

  // Entered and left on a falling edge; d = extra cycles before n_valid.
  task automatic do_op(input int op, input int a, input int n, input int fin, input int d);
    int r, f;
    model(op, a, n, fin & 1, r, f);
    drive_op_strobes(op);
    A_in = a[7:0]; F_in = fin[7:0]; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; set_strobes(7'd0, 1'b1);
    for (int k = 0; k <= d && k < TO; k++) begin
      check_val("n_req_wait", n_req, 1);
      check_val("busy_wait", busy, 1);
      check_val("done_wait", done, 0);
      if (k == d) begin
        n_valid = 1'b1; n_data = n[7:0]; start = 1'b0; set_strobes(7'd0, 1'b1);
      end else begin
        n_valid = 1'b0; n_data = 8'($urandom);
        start = 1'($urandom % 2);
        drive_op_strobes($urandom % 8);
      end
      @(negedge CLK);
    end
    start = 1'b0; set_strobes(7'd0, 1'b1);
    if (d < TO) begin
      n_valid = 1'($urandom % 2); n_data = 8'($urandom);
      check_val("n_req_exec", n_req, 0);
      check_val("done_exec", done, 0);
      check_val("busy_exec", busy, 1);
      @(negedge CLK);
      n_valid = 1'b0;
      check_val("A_out", A_out, r);
      check_val("F_out", F_out, f);
      check_val("A_we", A_we, (op != 7));
      check_val("F_we", F_we, 1);
      check_val("done_wb", done, 1);
      check_val("err_wb", err, 0);
      exp_a = r; exp_f = f;
    end else begin
      check_val("err_to", err, 1);
      check_val("done_to", done, 1);
      check_val("n_req_to", n_req, 0);
      check_val("A_we_to", A_we, 0);
      check_val("F_we_to", F_we, 0);
      check_val("A_hold_to", A_out, exp_a);
    end
    @(negedge CLK);
    check_val("done_after", done, 0);
    check_val("err_after", err, 0);
    check_val("F_we_after", F_we, 0);
    check_val("busy_after", busy, 0);
    check_val("A_hold", A_out, exp_a);
    check_val("F_hold", F_out, exp_f);
  endtask

  task automatic do_illegal(input logic [6:0] s);
    set_strobes(s, 1'b1); start = 1'b1;
    A_in = 8'($urandom); F_in = 8'($urandom);
    @(negedge CLK);
    start = 1'b0; set_strobes(7'd0, 1'b1);
    check_val("err_ill", err, 1);
    check_val("done_ill", done, 1);
    check_val("n_req_ill", n_req, 0);
    check_val("we_ill", {A_we, F_we}, 0);
    check_val("busy_ill", busy, 0);
    @(negedge CLK);
    check_val("err_ill_end", err, 0);
    check_val("n_req_ill_end", n_req, 0);
    check_val("A_hold_ill", A_out, exp_a);
  endtask

  initial begin
    logic [6:0] s;
    int kind;
    repeat (2) @(negedge CLK);
    check_val("rst_outs", {n_req, A_we, F_we, busy, done, err}, 0);
    check_val("rst_A", A_out, 0);
    check_val("rst_F", F_out, 0);
    notRESET = 1'b1;
    @(negedge CLK);

    do_op(0, 8'h7F, 8'h01, 0, 0);
    check_val("plan_add_A", A_out, 8'h80);
    check_val("plan_add_F", F_out, 8'h94);
    do_op(2, 8'h00, 8'h01, 0, 0);
    check_val("plan_sub_A", A_out, 8'hFF);
    check_val("plan_sub_F", F_out, 8'hBB);
    do_op(7, 8'h42, 8'h42, 0, 0);
    check_val("plan_cp_F", F_out, 8'h42);
    do_op(4, 8'hF0, 8'h3C, 0, 0);
    check_val("plan_and_A", A_out, 8'h30);
    check_val("plan_and_F", F_out, 8'h34);
    do_op(1, 8'hFF, 8'h00, 1, 0);
    check_val("plan_adc_A", A_out, 8'h00);
    check_val("plan_adc_F", F_out, 8'h51);
    do_op(3, 8'h10, 8'h0F, 1, 2);
    do_op(0, 8'h12, 8'h34, 0, TO);
    do_illegal(7'b1000100);
    do_illegal(7'b0000000);

    for (int it = 0; it < 200; it++) begin
      kind = $urandom % 8;
      if (kind == 0) begin
        s = 7'($urandom);
        while ($countones(s) == 1) s = 7'($urandom);
        do_illegal(s);
      end else if (kind == 1) begin
        do_op($urandom % 8, $urandom % 256, $urandom % 256, $urandom % 256, TO + ($urandom % 2));
      end else begin
        do_op($urandom % 8, $urandom % 256, $urandom % 256, $urandom % 256, $urandom % TO);
      end
    end

    // Reset pulled while waiting for the operand.
    do_op(0, 8'h7F, 8'h01, 0, 0);
    drive_op_strobes(0); A_in = 8'h11; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; set_strobes(7'd0, 1'b1);
    check_val("n_req_pre_rst", n_req, 1);
    notRESET = 1'b0;
    #1;
    check_val("midrst_outs", {n_req, A_we, F_we, busy, done, err}, 0);
    check_val("midrst_A", A_out, 0);
    check_val("midrst_F", F_out, 0);
    @(negedge CLK);
    notRESET = 1'b1;
    n_valid = 1'b1; n_data = 8'h22;
    exp_a = 0; exp_f = 0;
    repeat (3) begin
      @(negedge CLK);
      check_val("postrst_quiet", {n_req, A_we, F_we, busy, done, err}, 0);
      check_val("postrst_A", A_out, 0);
    end
    n_valid = 1'b0;
    do_op(5, 8'h0F, 8'hF0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
